if_id_buffer: RTL and testbench

- Two-entry elastic pipeline buffer between the instruction-fetch stage (program counter, incrementer, instruction memory) and the decode stage.
- Captures each fetched `{pc, instr}` pair with a valid/ready handshake, so decode can stall without losing fetched words.
- Decode can flush the buffer on a taken branch or jump.
- Also emits the sequential successor PC (`pc + 1`, word-addressed) for each held instruction.

---
 rtl/if_id_buffer.sv | 138 +++++++++++++
 tb/tb_if_id_buffer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/if_id_buffer.sv
`default_nettype none
// ============================================================================
// Module      : if_id_buffer
// Description : Two-entry elastic buffer between instruction fetch and decode.
//               Holds {pc, instr} pairs behind a valid/ready handshake,
//               supports a decode-side flush and presents pc+1 of the head.
//               Optional macro IF_ID_BUFFER_STATS_EN adds stall/flush
//               counters as extra outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_buffer #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] NOP   = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0] in_instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] out_pc_next,
`ifdef IF_ID_BUFFER_STATS_EN
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_count,
`endif
  output logic [WIDTH-1:0] out_instr
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head_pc;
  logic [WIDTH-1:0] head_instr;
  logic [WIDTH-1:0] tail_pc;
  logic [WIDTH-1:0] tail_instr;
  logic             valid_q;

  // Handshake qualifiers; flush suppresses both directions.
  assign in_ready    = !rst && (state != FULL);
  assign push        = in_valid && in_ready && !flush;
  assign pop         = valid_q && out_ready && !flush;

  assign out_valid   = valid_q;
  assign out_pc      = head_pc;
  assign out_instr   = head_instr;
  assign out_pc_next = head_pc + {{(WIDTH-1){1'b0}}, 1'b1};

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  // Next occupancy; reset and flush override any handshake.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (push) state_next = ONE;
      ONE: begin
        if (push && !pop)      state_next = FULL;
        else if (pop && !push) state_next = EMPTY;
      end
      FULL:    if (pop) state_next = ONE;
      default: state_next = EMPTY;
    endcase
    if (flush || rst) state_next = EMPTY;
  end

  // Entry storage: head feeds the outputs directly, tail only fills when head
  // is occupied and not leaving. An emptied head shows NOP but keeps its pc.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      head_pc    <= {WIDTH{1'b0}};
      head_instr <= NOP;
      tail_pc    <= {WIDTH{1'b0}};
      tail_instr <= NOP;
    end else begin
      valid_q <= (state_next != EMPTY);
      if (flush) begin
        head_instr <= NOP;
      end else begin
        case (state)
          EMPTY: begin
            if (push) begin
              head_pc    <= in_pc;
              head_instr <= in_instr;
            end
          end
          ONE: begin
            if (push && pop) begin
              head_pc    <= in_pc;
              head_instr <= in_instr;
            end else if (push) begin
              tail_pc    <= in_pc;
              tail_instr <= in_instr;
            end else if (pop) begin
              head_instr <= NOP;
            end
          end
          FULL: begin
            if (pop) begin
              head_pc    <= tail_pc;
              head_instr <= tail_instr;
            end
          end
          default: head_instr <= NOP;
        endcase
      end
    end
  end

`ifdef IF_ID_BUFFER_STATS_EN
  // Free-running wrap-around counters of decode stalls and flush requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= 32'd0;
      flush_count  <= 32'd0;
    end else begin
      if (valid_q && !out_ready && !flush) stall_cycles <= stall_cycles + 32'd1;
      if (flush)                           flush_count  <= flush_count + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_id_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_buffer
// Description : Directed self-checking bench for if_id_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc_next;
  logic [31:0] out_instr;
`ifdef IF_ID_BUFFER_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
  logic [31:0] stall_snap;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_id_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_instr    (in_instr),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_pc_next (out_pc_next),
`ifdef IF_ID_BUFFER_STATS_EN
    .stall_cycles(stall_cycles),
    .flush_count (flush_count),
`endif
    .out_instr   (out_instr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held two cycles with fetch presenting a beat.
    rst = 1'b1; in_valid = 1'b1; in_pc = 32'h55; in_instr = 32'hDEAD_BEEF;
    flush = 1'b0; out_ready = 1'b0;
    step();
    check("rst_in_ready_c1", {31'd0, in_ready}, 32'd0);
    step();
    check("rst_in_ready_c2", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_pc_next", out_pc_next, 32'd1);
    check("rst_out_instr", out_instr, 32'h0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Streaming pc 0..7 with decode always ready.
    out_ready = 1'b1; in_valid = 1'b1;
    for (int p = 0; p < 8; p++) begin
      in_pc = p; in_instr = 32'hA000_0000 + p;
      step();
      check("stream_valid", {31'd0, out_valid}, 32'd1);
      check("stream_pc", out_pc, p);
      check("stream_instr", out_instr, 32'hA000_0000 + p);
      check("stream_pc_next", out_pc_next, p + 1);
      check("stream_in_ready", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    check("drain_valid", {31'd0, out_valid}, 32'd0);
    check("drain_instr_nop", out_instr, 32'h0);
    check("drain_pc_hold", out_pc, 32'd7);

    // Backpressure: pc 5, 6 accepted, 7 held off.
    out_ready = 1'b0; in_valid = 1'b1;
    in_pc = 32'd5; in_instr = 32'hB5;
    step();
    check("bp_ready_after_1", {31'd0, in_ready}, 32'd1);
    in_pc = 32'd6; in_instr = 32'hB6;
    step();
    check("bp_ready_after_2", {31'd0, in_ready}, 32'd0);
    check("bp_head_5", out_pc, 32'd5);
    in_pc = 32'd7; in_instr = 32'hB7;
    step();
    check("bp_held_ready", {31'd0, in_ready}, 32'd0);
    check("bp_held_head", out_pc, 32'd5);
    check("bp_held_instr", out_instr, 32'hB5);
    out_ready = 1'b1;
    step();
    check("bp_deliver_6", out_pc, 32'd6);
    check("bp_deliver_6_instr", out_instr, 32'hB6);
    step();
    check("bp_deliver_7", out_pc, 32'd7);
    check("bp_deliver_7_instr", out_instr, 32'hB7);
    in_valid = 1'b0;
    step();
    check("bp_empty", {31'd0, out_valid}, 32'd0);

    // Flush while full with a simultaneous incoming beat.
    out_ready = 1'b0; in_valid = 1'b1;
    in_pc = 32'h10; in_instr = 32'hC10;
    step();
    in_pc = 32'h11; in_instr = 32'hC11;
    step();
    in_pc = 32'd9; in_instr = 32'hC09; flush = 1'b1;
    #1;
    check("flush_pre_ready", {31'd0, in_ready}, 32'd0);
    step();
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    check("flush_instr_nop", out_instr, 32'h0);
`ifdef IF_ID_BUFFER_STATS_EN
    check("flush_count", flush_count, 32'd1);
`endif
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("flush_no_pc9", {31'd0, out_valid}, 32'd0);

    // Successor pc wraps at the top of the address space.
    out_ready = 1'b0; in_valid = 1'b1;
    in_pc = 32'hFFFF_FFFF; in_instr = 32'h1234_5678;
    step();
    check("wrap_pc", out_pc, 32'hFFFF_FFFF);
    check("wrap_pc_next", out_pc_next, 32'h0);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("wrap_drain", {31'd0, out_valid}, 32'd0);

    // Simultaneous push/pop in ONE for four cycles.
    out_ready = 1'b0; in_valid = 1'b1;
    in_pc = 32'h20; in_instr = 32'hD20;
    step();
    out_ready = 1'b1;
`ifdef IF_ID_BUFFER_STATS_EN
    stall_snap = stall_cycles;
`endif
    for (int k = 1; k <= 4; k++) begin
      in_pc = 32'h20 + k; in_instr = 32'hD20 + k;
      step();
      check("one_valid", {31'd0, out_valid}, 32'd1);
      check("one_in_ready", {31'd0, in_ready}, 32'd1);
      check("one_pc", out_pc, 32'h20 + k);
    end
`ifdef IF_ID_BUFFER_STATS_EN
    check("one_stall_unchanged", stall_cycles, stall_snap);
`endif

    // Reset mid-operation discards the held entry, even with flush.
    in_valid = 1'b0; out_ready = 1'b0;
    rst = 1'b1; flush = 1'b1;
    #1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_pc", out_pc, 32'd0);
    rst = 1'b0; flush = 1'b0;
    #1;
    check("midrst_release_ready", {31'd0, in_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
